l1d_port_arbiter: RTL and testbench

- Shares the single L1 data-cache request port between two requesters:
  - the core load path (LD);
  - the store-queue drain path (DR), which writes committed stores to the cache.
- Sits between the store queue / load unit and the cache.
- Arbitrates with load priority plus an anti-starvation counter, tracks the 1-cycle cache response, and retries nacked drains with a fixed backoff.

---
 rtl/l1d_arb_pkg.sv | 27 ++
 rtl/l1d_arb_starve_ctr.sv | 31 +++
 rtl/l1d_port_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_l1d_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1d_arb_pkg.sv
// Shared types for the L1D port arbiter: FSM state codes, held-store record, counter sizing.
// No logic; pure declarations.
// Widths of dr_req_t follow the package defaults, which the top's parameters default to.
package l1d_arb_pkg;

  localparam int L1D_WADDR_W = 30;
  localparam int L1D_DATA_W  = 32;

  // Arbiter FSM state, kept as plain codes so older tooling reads them unchanged
  typedef logic [1:0] arb_state_e;
  localparam arb_state_e IDLE    = 2'd0;
  localparam arb_state_e DR_WAIT = 2'd1;
  localparam arb_state_e BACKOFF = 2'd2;

  // Store captured from the queue head and replayed until the cache accepts it
  typedef struct packed {
    logic [L1D_WADDR_W-1:0]  addr;
    logic [L1D_DATA_W/8-1:0] mask;
    logic [L1D_DATA_W-1:0]   data;
  } dr_req_t;

  // Bits needed to hold 0..max_val without wrapping
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/l1d_arb_starve_ctr.sv
// Saturating up-counter with synchronous clear and force-to-max, used to track lost drain arbitrations.
// Latency: count updates one cycle after inc/clr/force_max.
// No backpressure; force_max has priority over clr, clr over inc.
module l1d_arb_starve_ctr
  import l1d_arb_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic         force_max,
  output logic [W-1:0] cnt
);

  // Count lost arbitrations, stopping at MAX so it never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (force_max) begin
      cnt <= W'(MAX);
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/l1d_port_arbiter.sv
// Shares the single L1D request port between the load path and the store-queue drain path.
// Latency: request issued in the grant cycle, response consumed the following cycle.
// Backpressure: ld_ready/dr_ready deassert when the port is taken; nacked drains retry after a backoff.
// Optional: define L1D_ARB_PERF_EN to add 32-bit grant/nack performance counters.
module l1d_port_arbiter
  import l1d_arb_pkg::*;
#(
  parameter int WADDR_W     = L1D_WADDR_W,
  parameter int DATA_W      = L1D_DATA_W,
  parameter int STARVE_MAX  = 4,
  parameter int BACKOFF_CYC = 2,
  parameter int MAX_RETRY   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_valid,
  input  logic [WADDR_W-1:0]  ld_addr,
  input  logic [DATA_W/8-1:0] ld_mask,
  output logic                ld_ready,
  output logic                ld_resp_valid,
  output logic                ld_nack,
  output logic [DATA_W-1:0]   ld_data,
  input  logic                dr_valid,
  input  logic [WADDR_W-1:0]  dr_addr,
  input  logic [DATA_W/8-1:0] dr_mask,
  input  logic [DATA_W-1:0]   dr_data,
  output logic                dr_ready,
  output logic                dr_done,
  output logic                dr_err,
  output logic                cache_en,
  output logic                cache_en_w,
  output logic [WADDR_W-1:0]  cache_addr,
  output logic [DATA_W/8-1:0] cache_mask,
  output logic [DATA_W-1:0]   cache_req_data,
  input  logic                cache_nack,
  input  logic [DATA_W-1:0]   cache_resp_data
`ifdef L1D_ARB_PERF_EN
  ,
  output logic [31:0]         perf_ld_grants,
  output logic [31:0]         perf_dr_grants,
  output logic [31:0]         perf_dr_nacks
`endif
);

  localparam int SV_W = cnt_w(STARVE_MAX);
  localparam int RT_W = cnt_w(MAX_RETRY + 1);
  localparam int BO_W = cnt_w(BACKOFF_CYC);

  arb_state_e      state_q, state_d;
  logic [BO_W-1:0] bo_q, bo_d;
  logic [RT_W-1:0] retry_q;
  logic            err_q;
  logic            hold_vld_q;
  dr_req_t         hold_q;
  logic            last_ld_q;
  logic [SV_W-1:0] starve_cnt;
  logic            starve_at_max;
  logic            ld_grant;
  logic            dr_grant;
  logic            dr_ok;
  logic            dr_nk;
  logic            bo_last;

  assign starve_at_max = (starve_cnt == SV_W'(STARVE_MAX));
  assign bo_last       = (state_q == BACKOFF) && (bo_q == BO_W'(1));

  // Drain wins when loads are quiet or once it has lost STARVE_MAX times in a row
  assign dr_grant = !rst && (state_q == IDLE) && hold_vld_q && (!ld_valid || starve_at_max);
  // Loads use the port whenever the drain is not holding or claiming it
  assign ld_grant = !rst && ld_valid &&
                    (((state_q == IDLE) && !dr_grant) || (state_q == BACKOFF));

  // Drain response decode; a request abandoned by reset is never looked at
  assign dr_ok = !rst && (state_q == DR_WAIT) && !cache_nack;
  assign dr_nk = !rst && (state_q == DR_WAIT) && cache_nack;

  assign ld_ready      = ld_grant;
  assign dr_ready      = !rst && (state_q == IDLE) && !hold_vld_q;
  assign dr_done       = dr_ok;
  assign dr_err        = err_q;
  assign ld_resp_valid = last_ld_q && !rst;
  assign ld_nack       = ld_resp_valid && cache_nack;
  assign ld_data       = ld_resp_valid ? cache_resp_data : '0;

  // Drive the cache port from the held store or the live load request
  always_comb begin
    cache_en       = 1'b0;
    cache_en_w     = 1'b0;
    cache_addr     = '0;
    cache_mask     = '0;
    cache_req_data = '0;
    if (dr_grant) begin
      cache_en       = 1'b1;
      cache_en_w     = 1'b1;
      cache_addr     = hold_q.addr;
      cache_mask     = hold_q.mask;
      cache_req_data = hold_q.data;
    end else if (ld_grant) begin
      cache_en   = 1'b1;
      cache_addr = ld_addr;
      cache_mask = ld_mask;
    end
  end

  // Next-state and backoff countdown
  always_comb begin
    state_d = state_q;
    bo_d    = bo_q;
    case (state_q)
      IDLE: begin
        if (dr_grant) state_d = DR_WAIT;
      end
      DR_WAIT: begin
        if (cache_nack) begin
          state_d = BACKOFF;
          bo_d    = BO_W'(BACKOFF_CYC);
        end else begin
          state_d = IDLE;
        end
      end
      BACKOFF: begin
        if (bo_last) begin
          state_d = IDLE;
          bo_d    = '0;
        end else begin
          bo_d = bo_q - BO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        bo_d    = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bo_q    <= '0;
    end else begin
      state_q <= state_d;
      bo_q    <= bo_d;
    end
  end

  // Holding register: filled from the queue head, released only on a successful write
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else if (dr_ok) begin
      hold_vld_q <= 1'b0;
    end else if (dr_valid && dr_ready) begin
      hold_vld_q  <= 1'b1;
      hold_q.addr <= dr_addr;
      hold_q.mask <= dr_mask;
      hold_q.data <= dr_data;
    end
  end

  // Tag for next cycle's response: set when this cycle's request was a load
  always_ff @(posedge clk) begin
    if (rst) last_ld_q <= 1'b0;
    else     last_ld_q <= ld_grant;
  end

  // Retry count per store and sticky error once the limit is passed
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_q <= '0;
      err_q   <= 1'b0;
    end else if (dr_ok) begin
      retry_q <= '0;
    end else if (dr_nk) begin
      if (retry_q != RT_W'(MAX_RETRY + 1)) retry_q <= retry_q + RT_W'(1);
      if (retry_q >= RT_W'(MAX_RETRY)) err_q <= 1'b1;
    end
  end

  l1d_arb_starve_ctr #(
    .MAX (STARVE_MAX),
    .W   (SV_W)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .inc       ((state_q == IDLE) && hold_vld_q && ld_grant),
    .clr       (dr_grant),
    .force_max (bo_last && !rst),
    .cnt       (starve_cnt)
  );

`ifdef L1D_ARB_PERF_EN
  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ld_grants <= '0;
      perf_dr_grants <= '0;
      perf_dr_nacks  <= '0;
    end else begin
      if (ld_grant) perf_ld_grants <= perf_ld_grants + 32'd1;
      if (dr_grant) perf_dr_grants <= perf_dr_grants + 32'd1;
      if (dr_nk)    perf_dr_nacks  <= perf_dr_nacks + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1d_port_arbiter.sv
// Directed-vector bench for l1d_port_arbiter: per-cycle input/expected-output table plus a hand-written
// sequence covering a new store offered while one is already held.
module tb_l1d_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [29:0] ld_addr;
  logic [3:0]  ld_mask;
  logic        ld_ready, ld_resp_valid, ld_nack;
  logic [31:0] ld_data;
  logic        dr_valid;
  logic [29:0] dr_addr;
  logic [3:0]  dr_mask;
  logic [31:0] dr_data;
  logic        dr_ready, dr_done, dr_err;
  logic        cache_en, cache_en_w;
  logic [29:0] cache_addr;
  logic [3:0]  cache_mask;
  logic [31:0] cache_req_data;
  logic        cache_nack;
  logic [31:0] cache_resp_data;
`ifdef L1D_ARB_PERF_EN
  logic [31:0] perf_ld_grants, perf_dr_grants, perf_dr_nacks;
`endif

  always #5 clk = ~clk;

  l1d_port_arbiter dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_mask(ld_mask), .ld_ready(ld_ready),
    .ld_resp_valid(ld_resp_valid), .ld_nack(ld_nack), .ld_data(ld_data),
    .dr_valid(dr_valid), .dr_addr(dr_addr), .dr_mask(dr_mask), .dr_data(dr_data),
    .dr_ready(dr_ready), .dr_done(dr_done), .dr_err(dr_err),
    .cache_en(cache_en), .cache_en_w(cache_en_w), .cache_addr(cache_addr),
    .cache_mask(cache_mask), .cache_req_data(cache_req_data),
    .cache_nack(cache_nack), .cache_resp_data(cache_resp_data)
`ifdef L1D_ARB_PERF_EN
    , .perf_ld_grants(perf_ld_grants), .perf_dr_grants(perf_dr_grants), .perf_dr_nacks(perf_dr_nacks)
`endif
  );

  localparam logic [3:0] LD_M = 4'hA;
  localparam logic [3:0] DR_M = 4'h5;

  typedef struct packed {
    logic        rst;
    logic        ld_valid;
    logic [29:0] ld_addr;
    logic        dr_valid;
    logic [29:0] dr_addr;
    logic [31:0] dr_data;
    logic        cache_nack;
    logic [31:0] cache_resp_data;
  } in_t;

  typedef struct packed {
    logic        ld_ready;
    logic        ld_resp_valid;
    logic        ld_nack;
    logic [31:0] ld_data;
    logic        dr_ready;
    logic        dr_done;
    logic        dr_err;
    logic        cache_en;
    logic        cache_en_w;
    logic [29:0] cache_addr;
    logic [3:0]  cache_mask;
    logic [31:0] cache_req_data;
  } out_t;

  // mode 0: no check (cycle with reset asserted), 1: data fields only where meaningful, 2: every bit
  typedef struct {
    in_t  i;
    out_t o;
    int   mode;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic in_t vi(bit r, bit ldv, logic [29:0] lda, bit drv, logic [29:0] dra,
                             logic [31:0] drd, bit nk, logic [31:0] rd);
    in_t x;
    x.rst = r; x.ld_valid = ldv; x.ld_addr = lda; x.dr_valid = drv; x.dr_addr = dra;
    x.dr_data = drd; x.cache_nack = nk; x.cache_resp_data = rd;
    return x;
  endfunction

  function automatic out_t vo(bit ldr, bit rv, bit nk, logic [31:0] ldd, bit drr, bit done, bit err,
                              bit en, bit w, logic [29:0] a, logic [31:0] wd);
    out_t x;
    x.ld_ready = ldr; x.ld_resp_valid = rv; x.ld_nack = nk; x.ld_data = ldd;
    x.dr_ready = drr; x.dr_done = done; x.dr_err = err; x.cache_en = en; x.cache_en_w = w;
    x.cache_addr = a; x.cache_mask = en ? (w ? DR_M : LD_M) : 4'h0; x.cache_req_data = wd;
    return x;
  endfunction

  task automatic add(in_t i, out_t o, int mode);
    vec_t v;
    v.i = i; v.o = o; v.mode = mode;
    vecs.push_back(v);
  endtask

  task automatic drive(in_t i);
    rst = i.rst; ld_valid = i.ld_valid; ld_addr = i.ld_addr; ld_mask = LD_M;
    dr_valid = i.dr_valid; dr_addr = i.dr_addr; dr_mask = DR_M; dr_data = i.dr_data;
    cache_nack = i.cache_nack; cache_resp_data = i.cache_resp_data;
  endtask

  function automatic out_t sample();
    out_t x;
    x.ld_ready = ld_ready; x.ld_resp_valid = ld_resp_valid; x.ld_nack = ld_nack; x.ld_data = ld_data;
    x.dr_ready = dr_ready; x.dr_done = dr_done; x.dr_err = dr_err; x.cache_en = cache_en;
    x.cache_en_w = cache_en_w; x.cache_addr = cache_addr; x.cache_mask = cache_mask;
    x.cache_req_data = cache_req_data;
    return x;
  endfunction

  // Ignore payload fields the interface leaves undefined in this cycle
  function automatic out_t care(out_t x, out_t e);
    out_t y = x;
    if (!e.ld_resp_valid) y.ld_data = '0;
    if (!e.cache_en) begin
      y.cache_addr = '0; y.cache_mask = '0; y.cache_req_data = '0;
    end
    if (!e.cache_en_w) y.cache_req_data = '0;
    return y;
  endfunction

  task automatic check_vec(string nm, out_t act, out_t exp, int mode);
    out_t a, e;
    a = (mode == 2) ? act : care(act, exp);
    e = (mode == 2) ? exp : care(exp, exp);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic check_val(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    in_t  i0;
    out_t o0, o_rdy;
    bit   found;

    i0    = vi(0, 0, 0, 0, 0, 0, 0, 0);
    o0    = vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    o_rdy = vo(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Reset, then idle with the holding register empty
    add(vi(1, 0, 0, 0, 0, 0, 0, 0), o0, 0);
    add(vi(1, 0, 0, 0, 0, 0, 0, 0), o0, 0);
    add(i0, o_rdy, 2);

    // Five back-to-back loads; response data and nack follow one cycle later
    add(vi(0, 1, 'h100, 0, 0, 0, 0, 0),           vo(1, 0, 0, 0,            1, 0, 0, 1, 0, 'h100, 0), 1);
    add(vi(0, 1, 'h101, 0, 0, 0, 0, 'h11110000),  vo(1, 1, 0, 'h11110000,   1, 0, 0, 1, 0, 'h101, 0), 1);
    add(vi(0, 1, 'h102, 0, 0, 0, 0, 'h11110001),  vo(1, 1, 0, 'h11110001,   1, 0, 0, 1, 0, 'h102, 0), 1);
    add(vi(0, 1, 'h103, 0, 0, 0, 1, 'h11110002),  vo(1, 1, 1, 'h11110002,   1, 0, 0, 1, 0, 'h103, 0), 1);
    add(vi(0, 1, 'h104, 0, 0, 0, 0, 'h11110003),  vo(1, 1, 0, 'h11110003,   1, 0, 0, 1, 0, 'h104, 0), 1);
    add(vi(0, 0, 0, 0, 0, 0, 0, 'h11110004),      vo(0, 1, 0, 'h11110004,   1, 0, 0, 0, 0, 0, 0), 1);
    add(i0, o_rdy, 1);

    // Single store, no load traffic; live dr_* inputs changed after capture
    add(vi(0, 0, 0, 1, 'h10, 'hDEADBEEF, 0, 0), o_rdy, 1);
    add(vi(0, 0, 0, 0, 'h3FF, 0, 0, 0),          vo(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h10, 'hDEADBEEF), 1);
    add(i0,                                      vo(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1);
    add(i0, o_rdy, 1);

    // Store pending under continuous loads: four load wins, then the drain is forced through
    add(vi(0, 1, 'h200, 1, 'h20, 'hCAFE0001, 0, 0), vo(1, 0, 0, 0, 1, 0, 0, 1, 0, 'h200, 0), 1);
    for (int j = 1; j <= 4; j++)
      add(vi(0, 1, 30'h200 + 30'(j), 0, 0, 0, 0, 32'hA0 + 32'(j - 1)),
          vo(1, 1, 0, 32'hA0 + 32'(j - 1), 0, 0, 0, 1, 0, 30'h200 + 30'(j), 0), 1);
    add(vi(0, 1, 'h205, 0, 0, 0, 0, 'hA4), vo(0, 1, 0, 'hA4, 0, 0, 0, 1, 1, 'h20, 'hCAFE0001), 1);
    add(vi(0, 1, 'h205, 0, 0, 0, 0, 0),    vo(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1);
    add(vi(0, 1, 'h205, 0, 0, 0, 0, 0),    vo(1, 0, 0, 0, 1, 0, 0, 1, 0, 'h205, 0), 1);
    add(vi(0, 0, 0, 0, 0, 0, 0, 'hB5),     vo(0, 1, 0, 'hB5, 1, 0, 0, 0, 0, 0, 0), 1);

    // One nack: two backoff cycles serving loads, then the drain re-issues ahead of loads
    add(vi(0, 0, 0, 1, 'h30, 'h12345678, 0, 0), o_rdy, 1);
    add(i0,                                   vo(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h30, 'h12345678), 1);
    add(vi(0, 1, 'h300, 0, 0, 0, 1, 0),       o0, 1);
    add(vi(0, 1, 'h300, 0, 0, 0, 0, 0),       vo(1, 0, 0, 0,    0, 0, 0, 1, 0, 'h300, 0), 1);
    add(vi(0, 1, 'h301, 0, 0, 0, 0, 'hC0),    vo(1, 1, 0, 'hC0, 0, 0, 0, 1, 0, 'h301, 0), 1);
    add(vi(0, 1, 'h302, 0, 0, 0, 0, 'hC1),    vo(0, 1, 0, 'hC1, 0, 0, 0, 1, 1, 'h30, 'h12345678), 1);
    add(i0,                                   vo(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1);
    add(i0, o_rdy, 1);

    // Eight nacks: error rises after the eighth, store keeps retrying and finally lands
    add(vi(0, 0, 0, 1, 'h40, 'h55AA55AA, 0, 0), o_rdy, 1);
    for (int k = 1; k <= 8; k++) begin
      add(i0, vo(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h40, 'h55AA55AA), 1);
      add(vi(0, 0, 0, 0, 0, 0, 1, 0), o0, 1);
      add(i0, vo(0, 0, 0, 0, 0, 0, (k == 8), 0, 0, 0, 0), 1);
      add(i0, vo(0, 0, 0, 0, 0, 0, (k == 8), 0, 0, 0, 0), 1);
    end
    add(i0, vo(0, 0, 0, 0, 0, 0, 1, 1, 1, 'h40, 'h55AA55AA), 1);
    add(i0, vo(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), 1);
    add(i0, vo(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1);

    // Reset while waiting on a drain response: error cleared, store dropped, late nack ignored
    add(vi(0, 0, 0, 1, 'h50, 'h0BADF00D, 0, 0), vo(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1);
    add(i0, vo(0, 0, 0, 0, 0, 0, 1, 1, 1, 'h50, 'h0BADF00D), 1);
    add(vi(1, 0, 0, 0, 0, 0, 1, 0), o0, 0);
    add(vi(0, 0, 0, 0, 0, 0, 1, 'hFFFFFFFF), o_rdy, 2);
    add(i0, o_rdy, 2);

    drive(vi(1, 0, 0, 0, 0, 0, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].i);
      #2;
      if (vecs[k].mode != 0) check_vec($sformatf("vec%0d", k), sample(), vecs[k].o, vecs[k].mode);
    end

    // A second store offered while the first is held must wait for dr_ready
    @(negedge clk);
    drive(vi(0, 0, 0, 1, 'h60, 'h600D0001, 0, 0));
    #2 check_val("hs_capA_ready", 64'(dr_ready), 64'd1);
    @(negedge clk);
    drive(vi(0, 0, 0, 1, 'h61, 'h600D0002, 0, 0));
    #2 check_val("hs_grantA", {cache_en_w, cache_addr, cache_req_data}, {1'b1, 30'h60, 32'h600D0001});
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      #2;
      if (dr_done) found = 1'b1;
      else check_val("hs_heldA_ready", 64'(dr_ready), 64'd0);
    end
    check_val("hs_doneA_seen", 64'(found), 64'd1);
    @(negedge clk);
    #2 check_val("hs_capB_ready", 64'(dr_ready), 64'd1);
    @(negedge clk);
    drive(vi(0, 0, 0, 0, 0, 0, 0, 0));
    #2 check_val("hs_grantB", {cache_en_w, cache_addr, cache_req_data}, {1'b1, 30'h61, 32'h600D0002});
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      #2;
      if (dr_done) found = 1'b1;
    end
    check_val("hs_doneB_seen", 64'(found), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
